// File: rtl/ipu_input.sv
// Grid push-button input unit: synchronize, debounce, encode, interrupt.
// Optional rejected-press counter enabled by defining IPU_ERR_CNT_EN.
module ipu_input #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] btn,
    input  logic       int_ack,
    output logic [3:0] coord_out,
    output logic       write_en,
    output logic       ipu_int
`ifdef IPU_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        LATCH,
        INT,
        WAIT_RELEASE
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [8:0] meta_q, sync;
    logic [8:0] snap_q, snap_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] coord_q, coord_d;

    function automatic logic [3:0] enc(input logic [8:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic onehot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= 9'd0;
            sync    <= 9'd0;
            state_q <= IDLE;
            snap_q  <= 9'd0;
            cnt_q   <= 8'd0;
            coord_q <= 4'd0;
        end else begin
            meta_q  <= btn;
            sync    <= meta_q;
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            coord_q <= coord_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        coord_d = coord_q;
        unique case (state_q)
            IDLE: begin
                if (sync != 9'd0) begin
                    state_d = DEBOUNCE;
                    snap_d  = sync;
                    cnt_d   = 8'd0;
                end
            end
            DEBOUNCE: begin
                if (sync == 9'd0) begin
                    state_d = IDLE;
                end else if (sync != snap_q) begin
                    snap_d = sync;
                    cnt_d  = 8'd0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = 8'd0;
                    // multi-button chords are rejected, not encoded
                    if (onehot(snap_q)) begin
                        state_d = LATCH;
                        coord_d = enc(snap_q);
                    end else begin
                        state_d = WAIT_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LATCH: begin
                state_d = INT;
            end
            INT: begin
                if (int_ack) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = 8'd0;
                end
            end
            WAIT_RELEASE: begin
                if (sync != 9'd0) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign coord_out = coord_q;
    assign write_en  = (state_q == LATCH);
    assign ipu_int   = (state_q == INT);

`ifdef IPU_ERR_CNT_EN
    logic [7:0] err_q;
    logic       reject;

    assign reject = (state_q == DEBOUNCE) && (state_d == WAIT_RELEASE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 8'd0;
        end else if (reject && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: doc/ipu_input.md
IPU_INPUT -- requirements
Module: ipu_input

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles required before accepting a press or a release (legal 2..255).
REQ-002 SHALL provide port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port btn  input  9  raw, asynchronous grid-cell buttons, bit i = cell i (row-major 0..8).
REQ-005 SHALL provide port int_ack  input  1  processor acknowledge of ipu_int.
REQ-006 SHALL provide port coord_out  output  4  encoded cell index 0..8 to the grid coordinate register.
REQ-007 SHALL provide port write_en  output  1  one-cycle load strobe for the grid coordinate register.
REQ-008 SHALL provide port ipu_int  output  1  level interrupt to the processor.
REQ-009 SHALL provide port err_cnt  output  8  rejected-press count, present only with IPU_ERR_CNT_EN.

Function
REQ-010 SHALL pass btn through a 2-flop synchronizer; only the synchronized vector (sync) is used downstream.
REQ-011 SHALL implement FSM states IDLE, DEBOUNCE, LATCH, INT, WAIT_RELEASE.
REQ-012 IDLE: on sync != 0 SHALL go to DEBOUNCE, snapshot sync, clear the debounce counter.
REQ-013 DEBOUNCE: if sync == 0, SHALL return to IDLE; if sync != snapshot, SHALL re-snapshot and clear the counter; otherwise SHALL increment the counter.
REQ-014 DEBOUNCE: when the counter equals DEBOUNCE_CYCLES-1 with sync == snapshot, SHALL go to LATCH if snapshot is one-hot, else to WAIT_RELEASE (rejected press).
REQ-015 LATCH: SHALL drive write_en=1 and coord_out=index of the set bit for exactly one cycle, then go to INT.
REQ-016 coord_out SHALL hold its value from LATCH until the next LATCH; no value above 8 is ever output.
REQ-017 INT: SHALL hold ipu_int=1 until int_ack is sampled high, then go to WAIT_RELEASE; ipu_int is low the cycle after the ack edge.
REQ-018 int_ack SHALL be ignored in every state other than INT; if int_ack is already high on INT entry, INT SHALL last one cycle.
REQ-019 Button changes during LATCH/INT SHALL NOT alter coord_out or ipu_int and SHALL NOT queue a second press.
REQ-020 WAIT_RELEASE: SHALL go to IDLE only after sync == 0 for DEBOUNCE_CYCLES consecutive cycles; any nonzero sync restarts the count.
REQ-021 Outputs SHALL be Moore (registered state decode); latency pad-stable to write_en = DEBOUNCE_CYCLES+3 rising edges, ipu_int one edge later.

Reset
REQ-022 While rst is low, SHALL force state IDLE, synchronizer flops 0, counter 0, snapshot 0, coord_out 4'd0, write_en 0, ipu_int 0, err_cnt 0.
REQ-023 Reset asserted mid-operation (including INT) SHALL immediately drop ipu_int and write_en; no pending press survives reset.
REQ-024 After rst deasserts, a button already held SHALL be treated as a new press (IDLE -> DEBOUNCE).

Configuration
REQ-025 Macro IPU_ERR_CNT_EN defined: SHALL instantiate err_cnt, incrementing by 1 on each DEBOUNCE->WAIT_RELEASE rejection, saturating at 8'hFF.
REQ-026 Macro IPU_ERR_CNT_EN undefined: err_cnt port and counter SHALL be absent; rejection behaviour is otherwise identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 btn=9'h040 held from before edge 1 -> write_en high only in cycle after edge 7, coord_out=4'd6, ipu_int high from cycle after edge 8.
REQ-028 ipu_int high, int_ack pulsed one cycle -> ipu_int low next cycle; btn held -> no second write_en until 4 zero cycles then a new press.
REQ-029 btn=9'h003 stable 10 cycles -> no write_en, no ipu_int; err_cnt 0->1 (macro on).
REQ-030 btn=9'h010 toggling every 2 cycles for 20 cycles -> no write_en; then stable 9'h010 -> coord_out=4'd4, one write_en.
REQ-031 rst low for one cycle while ipu_int=1 -> ipu_int, write_en, coord_out all 0 immediately; btn still held -> fresh press after release of rst.
REQ-032 btn=9'h100 pressed, released after 2 stable cycles -> back to IDLE, no write_en; int_ack pulsed in IDLE -> no effect.
